dac_spi_reader: RTL and testbench

- Read-side consumer of the sample FIFO that the waveform generator fills.
- Pops one signed sample at a time when the FIFO is non-empty and enabled, then shifts it MSB-first to an external serial DAC.
- Uses SPI mode 0: sclk idle low, DAC samples on the rising edge.
- Paces FIFO draining, counts transmitted frames and flags underrun.

---
 rtl/fifo_defines_pkg.sv | 17 +
 rtl/spi_sclk_div.sv | 52 +++++
 rtl/dac_spi_reader.sv | 120 ++++++++++++
 tb/tb_dac_spi_reader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_defines_pkg.sv
// Shared definitions for the sample FIFO and its DAC read side.
package fifo_defines_pkg;

    localparam int unsigned DATA_WIDTH     = 16;
    localparam int unsigned SAMPLE_CNT_W   = 16;
    localparam int unsigned DAC_CLK_DIV    = 2;
    localparam int unsigned DAC_GAP_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LATCH,
        SHIFT,
        GAP
    } rd_state_t;

endpackage

// File: rtl/spi_sclk_div.sv
// Half-period counter for the DAC serial clock. Runs only while run_i is high;
// otherwise sclk_o is held low and the counter is cleared.
module spi_sclk_div #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    output logic rise_tick_o,
    output logic fall_tick_o,
    output logic sclk_o
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;
    logic             half_done;

    assign half_done   = run_i && (cnt_q == CNT_W'(CLK_DIV - 1));
    // Ticks flag the edge on which sclk will change level.
    assign rise_tick_o = half_done && !sclk_q;
    assign fall_tick_o = half_done && sclk_q;
    assign sclk_o      = sclk_q;

    // Next-state for the half-period counter and the sclk level.
    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!run_i) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (half_done) begin
            cnt_d  = '0;
            sclk_d = ~sclk_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter and sclk registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/dac_spi_reader.sv
// Drains the sample FIFO and shifts each sample MSB-first to a serial DAC
// (SPI mode 0). Counts completed frames and flags FIFO starvation.
// Optional build macro DAC_OFFSET_BINARY_EN: invert the sample MSB at capture
// so two's-complement samples go out as offset binary.
module dac_spi_reader
    import fifo_defines_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = fifo_defines_pkg::DATA_WIDTH,
    parameter int unsigned CLK_DIV    = DAC_CLK_DIV,
    parameter int unsigned GAP_CYCLES = DAC_GAP_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic                    empty_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    output logic                    rd_en_o,
    output logic                    cs_n_o,
    output logic                    sclk_o,
    output logic                    mosi_o,
    output logic                    busy_o,
    output logic [SAMPLE_CNT_W-1:0] sample_cnt_o,
    output logic                    underrun_o
);

    localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    rd_state_t               state_q, state_d;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic                    mosi_q;
    logic [BIT_W-1:0]        bit_cnt_q;
    logic [GAP_W-1:0]        gap_cnt_q;
    logic [SAMPLE_CNT_W-1:0] sample_cnt_q;
    logic                    underrun_q;
    logic                    rise_tick, fall_tick;
    logic [DATA_WIDTH-1:0]   sample;

    spi_sclk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_div (
        .clk         (clk),
        .rst         (rst),
        .run_i       (state_q == SHIFT),
        .rise_tick_o (rise_tick),
        .fall_tick_o (fall_tick),
        .sclk_o      (sclk_o)
    );

`ifdef DAC_OFFSET_BINARY_EN
    assign sample = {~data_i[DATA_WIDTH-1], data_i[DATA_WIDTH-2:0]};
`else
    assign sample = data_i;
`endif

    // Moore output decodes.
    assign rd_en_o      = (state_q == POP);
    assign cs_n_o       = !((state_q == LATCH) || (state_q == SHIFT));
    assign busy_o       = (state_q != IDLE);
    assign mosi_o       = mosi_q;
    assign sample_cnt_o = sample_cnt_q;
    assign underrun_o   = underrun_q;

    // Frame sequencing; the frame ends on the fall after the last rising edge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (en_i && !empty_i) state_d = POP;
            POP:   state_d = LATCH;
            LATCH: state_d = SHIFT;
            SHIFT: if (fall_tick && (bit_cnt_q == BIT_W'(DATA_WIDTH))) state_d = GAP;
            GAP:   if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Shift datapath, bit/gap counters, frame counter and underrun flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q      <= '0;
            mosi_q       <= 1'b0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            sample_cnt_q <= '0;
            underrun_q   <= 1'b0;
        end else begin
            if (state_q == LATCH) begin
                shift_q   <= sample;
                mosi_q    <= sample[DATA_WIDTH-1];
                bit_cnt_q <= '0;
            end else if (state_q == SHIFT) begin
                if (rise_tick) bit_cnt_q <= bit_cnt_q + 1'b1;
                if (fall_tick) begin
                    shift_q <= {shift_q[DATA_WIDTH-2:0], 1'b0};
                    mosi_q  <= shift_q[DATA_WIDTH-2];
                end
            end

            if (state_q == SHIFT && state_d == GAP) begin
                sample_cnt_q <= sample_cnt_q + 1'b1;
                gap_cnt_q    <= '0;
            end else if (state_q == GAP) begin
                gap_cnt_q <= gap_cnt_q + 1'b1;
            end

            if (!en_i) begin
                underrun_q <= 1'b0;
            end else if (state_q == IDLE && empty_i && sample_cnt_q != '0) begin
                underrun_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dac_spi_reader.sv
// Directed bench for dac_spi_reader with a FIFO model and a transmit scoreboard.
module tb_dac_spi_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_i = 1'b0;
    logic        empty_i;
    logic [15:0] data_i = 16'h0000;
    logic        rd_en_o, cs_n_o, sclk_o, mosi_o, busy_o, underrun_o;
    logic [15:0] sample_cnt_o;

    dac_spi_reader #(
        .DATA_WIDTH (16),
        .CLK_DIV    (2),
        .GAP_CYCLES (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en_i         (en_i),
        .empty_i      (empty_i),
        .data_i       (data_i),
        .rd_en_o      (rd_en_o),
        .cs_n_o       (cs_n_o),
        .sclk_o       (sclk_o),
        .mosi_o       (mosi_o),
        .busy_o       (busy_o),
        .sample_cnt_o (sample_cnt_o),
        .underrun_o   (underrun_o)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] fifo[$];
    logic [15:0] exp_q[$];
    int          start_q[$];
    int          low_q[$];
    int          cyc = 0;
    int          rd_cnt = 0;
    int          frames = 0;
    int          cs_low_total = 0;
    int          nbits = 0;
    int          low_cnt = 0;
    logic [15:0] bits = 16'h0;
    logic        cs_prev = 1'b1;
    logic        sclk_prev = 1'b0;
    logic        abort = 1'b0;

    assign empty_i = (fifo.size() == 0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] xform(input logic [15:0] d);
`ifdef DAC_OFFSET_BINARY_EN
        return {~d[15], d[14:0]};
`else
        return d;
`endif
    endfunction

    task automatic push(input logic [15:0] d);
        fifo.push_back(d);
        exp_q.push_back(xform(d));
    endtask

    // FIFO model and serial monitor, sampled on the falling clock edge.
    always @(negedge clk) begin
        cyc++;
        if (rd_en_o) begin
            rd_cnt++;
            check("pop_nonempty", {31'd0, fifo.size() != 0}, 32'd1);
            if (fifo.size() != 0) data_i = fifo.pop_front();
        end
        if (sclk_o && !sclk_prev) begin
            bits = {bits[14:0], mosi_o};
            nbits++;
        end
        if (!cs_n_o) begin
            cs_low_total++;
            if (cs_prev) begin
                start_q.push_back(cyc);
                low_cnt = 0;
            end
            low_cnt++;
        end else if (!cs_prev) begin
            if (abort) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end else begin
                frames++;
                low_q.push_back(low_cnt);
                check("frame_bits", nbits, 16);
                if (exp_q.size() == 0) check("sb_nonempty", 0, 1);
                else check("frame_data", bits, exp_q.pop_front());
            end
            nbits = 0;
        end
        cs_prev   = cs_n_o;
        sclk_prev = sclk_o;
    end

    task automatic wait_frames(input int n, input int budget);
        for (int i = 0; i < budget && frames < n; i++) @(negedge clk);
        check("tmo_frames", frames, n);
    endtask

    initial begin
        int f0;

        // 1: reset state, then idle with data present but disabled
        fifo.push_back(16'h1234);
        repeat (3) @(negedge clk);
        check("rst_rd_en", rd_en_o, 0);
        check("rst_cs_n", cs_n_o, 1);
        check("rst_sclk", sclk_o, 0);
        check("rst_mosi", mosi_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_cnt", sample_cnt_o, 0);
        check("rst_underrun", underrun_o, 0);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("dis_rd_cnt", rd_cnt, 0);
        check("dis_cs_low", cs_low_total, 0);
        check("dis_cnt", sample_cnt_o, 0);

        // 2: one frame of 0xA5C3
        fifo.delete();
        low_q.delete();
        push(16'hA5C3);
        en_i = 1'b1;
        wait_frames(1, 200);
        repeat (5) @(negedge clk);
        check("f1_rd_cnt", rd_cnt, 1);
        check("f1_cs_low", low_q.size() > 0 ? low_q[0] : -1, 65);
        check("f1_cnt", sample_cnt_o, 1);
        check("f1_underrun", underrun_o, 1);
        en_i = 1'b0;
        @(negedge clk);
        check("f1_underrun_clr", underrun_o, 0);

        // 3: three back-to-back frames
        start_q.delete();
        low_q.delete();
        push(16'h7FFF);
        push(16'h8001);
        push(16'h0F0F);
        en_i = 1'b1;
        wait_frames(4, 400);
        repeat (5) @(negedge clk);
        check("bb_starts", start_q.size(), 3);
        if (start_q.size() == 3 && low_q.size() == 3) begin
            check("bb_period0", start_q[1] - start_q[0], 69);
            check("bb_period1", start_q[2] - start_q[1], 69);
            check("bb_low0", low_q[0], 65);
            check("bb_low2", low_q[2], 65);
            // cs high span = GAP (2) + IDLE (1) + POP (1)
            check("bb_high0", start_q[1] - start_q[0] - low_q[0], 4);
        end
        check("bb_cnt", sample_cnt_o, 4);
        check("bb_underrun", underrun_o, 1);

        // 4: drop en_i mid-SHIFT, frame completes, no further pop
        en_i = 1'b0;
        @(negedge clk);
        check("en0_underrun_clr", underrun_o, 0);
        rd_cnt = 0;
        push(16'h3C5A);
        en_i = 1'b1;
        for (int i = 0; i < 50 && cs_n_o; i++) @(negedge clk);
        repeat (11) @(negedge clk);
        en_i = 1'b0;
        wait_frames(5, 200);
        push(16'h1111);
        repeat (100) @(negedge clk);
        check("en0_rd_cnt", rd_cnt, 1);
        check("en0_fifo", fifo.size(), 1);
        check("en0_busy", busy_o, 0);
        check("en0_underrun", underrun_o, 0);
        check("en0_cnt", sample_cnt_o, 5);

        // 5: reset at bit 7 of the 0x1111 frame
        push(16'h2222);
        en_i = 1'b1;
        for (int i = 0; i < 200 && nbits < 7; i++) @(negedge clk);
        check("tmo_bit7", nbits, 7);
        @(posedge clk);
        #2;
        rst   = 1'b1;
        en_i  = 1'b0;
        abort = 1'b1;
        #1;
        check("ar_cs_n", cs_n_o, 1);
        check("ar_sclk", sclk_o, 0);
        check("ar_busy", busy_o, 0);
        check("ar_cnt", sample_cnt_o, 0);
        check("ar_rd_en", rd_en_o, 0);
        repeat (3) @(posedge clk);
        abort = 1'b0;
        #2;
        rst = 1'b0;
        rd_cnt = 0;
        repeat (50) @(negedge clk);
        check("ar_rd_cnt", rd_cnt, 0);
        check("ar_fifo", fifo.size(), 1);
        f0 = frames;
        en_i = 1'b1;
        wait_frames(f0 + 1, 200);
        repeat (5) @(negedge clk);
        check("ar_restart_cnt", sample_cnt_o, 1);

        // 6: sign boundary samples (offset binary when the macro is defined)
        f0 = frames;
        push(16'h0000);
        push(16'hFFFF);
        wait_frames(f0 + 2, 400);
        repeat (5) @(negedge clk);
        check("ob_cnt", sample_cnt_o, 3);
        check("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
